// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for an 8-digit multiplexed seven-segment bus: filters, decodes and frames digits.
// Optional SCAN_CHANGE_ONLY_EN: discard completed frames identical to the last one loaded.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  AN,
  input  logic [7:0]  SEG,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [31:0] frame_value,
  output logic [7:0]  frame_dp,
  output logic        frame_err,
  output logic        overrun
);

  typedef enum logic [1:0] {S_SYNC, S_SETTLE, S_HOLD} state_t;

  localparam logic [CNT_W:0] LP_STABLE = (CNT_W+1)'(STABLE_CYCLES);
  localparam logic [CNT_W:0] LP_ONE    = (CNT_W+1)'(1);

  state_t             r_state;
  logic [7:0]         r_an_meta, r_an_sync, r_seg_meta, r_seg_sync;
  logic [7:0]         r_an_lat, r_seg_lat;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_mask;
  logic [31:0]        r_dig_nib;
  logic [7:0]         r_dig_dp, r_dig_err;
  logic               r_frame_valid;
  logic [31:0]        r_frame_value;
  logic [7:0]         r_frame_dp;
  logic               r_frame_err;
  logic               r_overrun;

  logic [7:0]         w_an_sel;
  logic               w_one_digit;
  logic [2:0]         w_idx;
  logic [3:0]         w_nib;
  logic               w_bad;
  logic [CNT_W:0]     w_cnt_next;
  logic               w_complete, w_accept, w_drop_same, w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_meta  <= 8'hFF;
      r_an_sync  <= 8'hFF;
      r_seg_meta <= 8'hFF;
      r_seg_sync <= 8'hFF;
    end else begin
      r_an_meta  <= AN;
      r_an_sync  <= r_an_meta;
      r_seg_meta <= SEG;
      r_seg_sync <= r_seg_meta;
    end
  end

  assign w_an_sel    = ~r_an_sync;
  assign w_one_digit = (w_an_sel != 8'h00) && ((w_an_sel & (w_an_sel - 8'h01)) == 8'h00);
  assign w_cnt_next  = {1'b0, r_cnt} + LP_ONE;

  always_comb begin
    w_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!r_an_lat[k]) w_idx = 3'(k);
    end
  end

  always_comb begin
    w_nib = 4'h0;
    w_bad = 1'b0;
    case (r_seg_lat[6:0])
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: w_bad = 1'b1;
    endcase
  end

  // A full mask is consumed by the frame logic one cycle after the last capture; the FSM is in HOLD then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_SYNC;
      r_an_lat  <= 8'hFF;
      r_seg_lat <= 8'hFF;
      r_cnt     <= '0;
      r_mask    <= 8'h00;
      r_dig_nib <= 32'h0;
      r_dig_dp  <= 8'h00;
      r_dig_err <= 8'h00;
    end else begin
      if (w_complete) begin
        r_mask    <= 8'h00;
        r_dig_err <= 8'h00;
      end
      case (r_state)
        S_SYNC: begin
          if (w_one_digit) begin
            r_an_lat  <= r_an_sync;
            r_seg_lat <= r_seg_sync;
            r_cnt     <= CNT_W'(1);
            r_state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if ({r_an_sync, r_seg_sync} != {r_an_lat, r_seg_lat}) begin
            r_cnt   <= '0;
            r_state <= S_SYNC;
          end else if (w_cnt_next >= LP_STABLE) begin
            r_dig_nib[{w_idx, 2'b00} +: 4] <= w_nib;
            r_dig_dp[w_idx]  <= ~r_seg_lat[7];
            r_dig_err[w_idx] <= w_bad;
            r_mask[w_idx]    <= 1'b1;
            r_state          <= S_HOLD;
          end else begin
            r_cnt <= w_cnt_next[CNT_W-1:0];
          end
        end
        S_HOLD: begin
          if (r_an_sync != r_an_lat) r_state <= S_SYNC;
        end
        default: r_state <= S_SYNC;
      endcase
    end
  end

  assign w_complete = (r_mask == 8'hFF);
  assign w_accept   = r_frame_valid && frame_ready;

`ifdef SCAN_CHANGE_ONLY_EN
  logic r_loaded_once;
  assign w_drop_same = r_loaded_once && (r_dig_nib == r_frame_value) &&
                       (r_dig_dp == r_frame_dp) && ((|r_dig_err) == r_frame_err);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_loaded_once <= 1'b0;
    else if (w_load) r_loaded_once <= 1'b1;
  end
`else
  assign w_drop_same = 1'b0;
`endif

  assign w_load = w_complete && !w_drop_same && (!r_frame_valid || w_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_frame_value <= 32'h0;
      r_frame_dp    <= 8'h00;
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (w_load) begin
      r_frame_valid <= 1'b1;
      r_frame_value <= r_dig_nib;
      r_frame_dp    <= r_dig_dp;
      r_frame_err   <= |r_dig_err;
    end else begin
      if (w_accept) r_frame_valid <= 1'b0;
      if (w_complete && !w_drop_same) r_overrun <= 1'b1;
    end
  end

  assign frame_valid = r_frame_valid;
  assign frame_value = r_frame_value;
  assign frame_dp    = r_frame_dp;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: drives scanned AN/SEG digits, scoreboard of expected frames.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  AN, SEG;
  logic        frame_ready;
  logic        frame_valid;
  logic [31:0] frame_value;
  logic [7:0]  frame_dp;
  logic        frame_err;
  logic        overrun;

  typedef struct packed {
    logic [31:0] v;
    logic [7:0]  dp;
    logic        err;
  } frame_t;

  frame_t sb[$];
  frame_t mon_exp;
  int total = 0;
  int bad = 0;
  int frames_seen = 0;

  seg_scan_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .AN(AN), .SEG(SEG), .frame_ready(frame_ready),
    .frame_valid(frame_valid), .frame_value(frame_value), .frame_dp(frame_dp),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Every accepted handshake pops one expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      frames_seen++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_frame got value=%h dp=%h err=%b", frame_value, frame_dp, frame_err);
      end else begin
        mon_exp = sb.pop_front();
        if ({frame_value, frame_dp, frame_err} !== mon_exp) begin
          bad++;
          $display("[TB] FAIL frame_contents got value=%h dp=%h err=%b want value=%h dp=%h err=%b",
                   frame_value, frame_dp, frame_err, mon_exp.v, mon_exp.dp, mon_exp.err);
        end
      end
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
      4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
      4'h8: enc = 7'h00; 4'h9: enc = 7'h10; 4'hA: enc = 7'h08; 4'hB: enc = 7'h03;
      4'hC: enc = 7'h46; 4'hD: enc = 7'h21; 4'hE: enc = 7'h06; default: enc = 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] seg_of(input logic [31:0] val, input logic [7:0] dp, input int d);
    seg_of = {~dp[d], enc(val[4*d +: 4])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_digit(input int d, input logic [7:0] seg, input int dwell);
    logic [7:0] one;
    one = 8'h01;
    AN  = ~(one << d);
    SEG = seg;
    repeat (dwell) tick();
  endtask

  task automatic scan_frame(input logic [31:0] val, input logic [7:0] dp, input int dwell);
    for (int d = 0; d < 8; d++) drive_digit(d, seg_of(val, dp, d), dwell);
  endtask

  task automatic wait_drain(input int limit, output bit ok);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    ok = (sb.size() == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    int n0;
    rst_n = 1'b0;
    repeat (4) begin
      AN  = 8'($urandom);
      SEG = 8'($urandom);
      tick();
    end
    total++; if (frame_valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset_valid got %b want 0", frame_valid); end
    total++; if (frame_value !== 32'h0)  begin bad++; $display("[TB] FAIL reset_value got %h want 0", frame_value); end
    total++; if (frame_dp !== 8'h00)     begin bad++; $display("[TB] FAIL reset_dp got %h want 0", frame_dp); end
    total++; if (frame_err !== 1'b0)     begin bad++; $display("[TB] FAIL reset_err got %b want 0", frame_err); end
    total++; if (overrun !== 1'b0)       begin bad++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
    AN = 8'hFF; SEG = 8'hFF;
    rst_n = 1'b1;
    n0 = frames_seen;
    for (int d = 0; d < 4; d++) drive_digit(d, seg_of(32'h12345678, 8'h00, d), 6);
    repeat (10) tick();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL partial_scan_valid got %b want 0", frame_valid); end
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int d = 4; d < 8; d++) drive_digit(d, seg_of(32'h12345678, 8'h00, d), 6);
    repeat (20) tick();
    total++; if (frame_valid !== 1'b0 || frames_seen != n0) begin
      bad++; $display("[TB] FAIL reset_discards_mask got valid=%b frames=%0d want valid=0 frames=%0d", frame_valid, frames_seen, n0);
    end
  endtask

  task automatic test_basic_scan();
    int n0;
    bit ok;
    do_reset();
    frame_ready = 1'b1;
    n0 = frames_seen;
    sb.push_back('{v: 32'h87654321, dp: 8'h00, err: 1'b0});
    scan_frame(32'h87654321, 8'h00, 6);
    wait_drain(60, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL basic_timeout got pending=%0d want 0", sb.size()); end
    repeat (10) tick();
    total++; if (frames_seen - n0 != 1) begin bad++; $display("[TB] FAIL basic_pulses got %0d want 1", frames_seen - n0); end
  endtask

  task automatic test_glitch();
    int n0;
    bit ok;
    logic [31:0] val;
    val = 32'h3C1F0A95;
    do_reset();
    frame_ready = 1'b1;
    n0 = frames_seen;
    for (int d = 0; d < 8; d++) drive_digit(d, seg_of(val, 8'h00, d), (d == 3) ? 2 : 6);
    repeat (20) tick();
    total++; if (frames_seen != n0 || frame_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL glitch_captured got frames=%0d valid=%b want frames=%0d valid=0", frames_seen - n0, frame_valid, 0);
    end
    sb.push_back('{v: val, dp: 8'h00, err: 1'b0});
    drive_digit(3, seg_of(val, 8'h00, 3), 6);
    wait_drain(40, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL glitch_recover_timeout got pending=%0d want 0", sb.size()); end
  endtask

  task automatic test_err_dp();
    bit ok;
    logic [31:0] val;
    val = 32'h01234567;
    do_reset();
    frame_ready = 1'b1;
    sb.push_back('{v: 32'h01034567, dp: 8'h01, err: 1'b1});
    for (int d = 0; d < 8; d++) begin
      if (d == 5) drive_digit(d, {1'b1, 7'h7F}, 6);
      else        drive_digit(d, seg_of(val, 8'h01, d), 6);
    end
    wait_drain(60, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL err_dp_timeout got pending=%0d want 0", sb.size()); end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    frame_ready = 1'b0;
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL overrun_initial got %b want 0", overrun); end
    scan_frame(32'hA5A55A5A, 8'h80, 6);
    scan_frame(32'h13572468, 8'h00, 6);
    repeat (10) tick();
    total++; if (frame_valid !== 1'b1) begin bad++; $display("[TB] FAIL overrun_held_valid got %b want 1", frame_valid); end
    total++; if (frame_value !== 32'hA5A55A5A) begin bad++; $display("[TB] FAIL overrun_held_value got %h want a5a55a5a", frame_value); end
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_flag got %b want 1", overrun); end
    sb.push_back('{v: 32'hA5A55A5A, dp: 8'h80, err: 1'b0});
    frame_ready = 1'b1;
    wait_drain(10, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL overrun_accept_timeout got pending=%0d want 0", sb.size()); end
    repeat (3) tick();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL overrun_valid_drop got %b want 0", frame_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_change_only();
    int n0;
    int want;
    bit ok;
    do_reset();
    frame_ready = 1'b1;
    n0 = frames_seen;
    sb.push_back('{v: 32'hDEADBEEF, dp: 8'h00, err: 1'b0});
`ifdef SCAN_CHANGE_ONLY_EN
    want = 1;
`else
    want = 2;
    sb.push_back('{v: 32'hDEADBEEF, dp: 8'h00, err: 1'b0});
`endif
    scan_frame(32'hDEADBEEF, 8'h00, 6);
    scan_frame(32'hDEADBEEF, 8'h00, 6);
    wait_drain(60, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL repeat_timeout got pending=%0d want 0", sb.size()); end
    repeat (20) tick();
    total++; if (frames_seen - n0 != want) begin bad++; $display("[TB] FAIL repeat_count got %0d want %0d", frames_seen - n0, want); end
  endtask

  initial begin
    rst_n = 1'b0;
    AN = 8'hFF;
    SEG = 8'hFF;
    frame_ready = 1'b1;
    test_reset();
    test_basic_scan();
    test_glitch();
    test_err_dp();
    test_overrun();
    test_change_only();
    sb.delete();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
